// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the ADC capture engine.
package adc_cap_pkg;

   // Capture controller states
   typedef enum logic [1:0] {
      CAP_IDLE = 2'd0,
      CAP_RUN  = 2'd1,
      CAP_DONE = 2'd2
   } cap_state_e;

   // Width of the source-channel tag placed in the sample MSBs when tagging is built in
   localparam int TAG_W = 3;

   // Index width that never collapses to zero bits
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adc_cap_rr_arb.sv
// Round-robin arbiter: one grant per cycle, search starts at the channel after the
// last granted one. The pointer only moves when something is granted.
module adc_cap_rr_arb
   import adc_cap_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = clog2_min1(N)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [N-1:0]  req_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   logic [IW-1:0] ptr_q, ptr_d;

   // Pick the first requester at or after the pointer, wrapping around
   always_comb begin
      int  c;
      logic found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < N; k++) begin
         c = (int'(ptr_q) + k) % N;
         if (!found && req_i[c]) begin
            found    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = IW'(c);
         end
      end
      vld_o = found;
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
      end
   end

   // Pointer register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/adc_capture_engine.sv
// N-channel ADC capture engine: per-channel hold registers, round-robin arbitration
// and bank-rotating SRAM writes with single-shot or ping-pong capture.
// Build option: define ADC_CAP_TAG_EN to replace the top TAG_W data bits with the
// source channel index.
module adc_capture_engine
   import adc_cap_pkg::*;
#(
   parameter int NCH   = 3,
   parameter int DW    = 32,
   parameter int AW    = 9,
   parameter int NBANK = 2,
   parameter int BW    = clog2_min1(NBANK)
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              pingpong_i,
   input  logic [AW-1:0]     last_addr_i,
   input  logic [NCH-1:0]    ch_en_i,
   input  logic [NCH-1:0]    adc_dvalid_i,
   input  logic [NCH*DW-1:0] adc_dat_i,
   output logic [NBANK-1:0]  mem_wenb_o,
   output logic [AW-1:0]     mem_waddr_o,
   output logic [DW-1:0]     mem_data_o,
   output logic [DW/8-1:0]   mem_wmask_o,
   output logic              busy_o,
   output logic [BW-1:0]     bank_o,
   output logic              irq_o,
   output logic [NCH-1:0]    ovf_o
);

   localparam int IW = clog2_min1(NCH);

   cap_state_e             state_q, state_d;
   logic                   pp_q;
   logic [AW-1:0]          last_q;
   logic [NCH-1:0]         chen_q;
   logic [NCH-1:0]         hold_vld_q, hold_vld_d;
   logic [NCH-1:0][DW-1:0] hold_dat_q, hold_dat_d;
   logic [NCH-1:0]         ovf_q, ovf_d;
   logic [AW-1:0]          waddr_q, waddr_d;
   logic [BW-1:0]          bank_q, bank_d;
   logic [NBANK-1:0]       wenb_q, wenb_d;
   logic [AW-1:0]          maddr_q, maddr_d;
   logic [DW-1:0]          mdata_q, mdata_d;
   logic                   irq_q, irq_d;

   logic                   run, start_acc, wr_en, full_last, flush;
   logic [NCH-1:0]         load, arb_req, arb_gnt;
   logic [IW-1:0]          arb_idx;
   logic                   arb_vld;
   logic [DW-1:0]          sel_dat, wr_word;

   assign run     = (state_q == CAP_RUN);
   // No grant on the stop cycle so nothing new is registered after an abort
   assign arb_req = hold_vld_q & {NCH{run && !stop_i}};

   adc_cap_rr_arb #(.N(NCH), .IW(IW)) u_arb (
      .clk_i  (wb_clk_i),
      .rst_ni (wb_rst_ni),
      .req_i  (arb_req),
      .gnt_o  (arb_gnt),
      .idx_o  (arb_idx),
      .vld_o  (arb_vld)
   );

   assign wr_en     = arb_vld;
   assign full_last = wr_en && (waddr_q == last_q) && (bank_q == BW'(NBANK - 1));
   assign sel_dat   = hold_dat_q[arb_idx];

`ifdef ADC_CAP_TAG_EN
   assign wr_word = {TAG_W'(arb_idx), sel_dat[DW-TAG_W-1:0]};
`else
   assign wr_word = sel_dat;
`endif

   // FSM next state; start is honoured only from IDLE/DONE and loses to stop
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      case (state_q)
         CAP_IDLE, CAP_DONE: begin
            if (start_i && !stop_i) begin
               state_d   = CAP_RUN;
               start_acc = 1'b1;
            end
         end
         CAP_RUN: begin
            if (stop_i) begin
               state_d = CAP_IDLE;
            end else if (full_last && !pp_q) begin
               state_d = CAP_DONE;
            end
         end
         default: state_d = CAP_IDLE;
      endcase
   end

   // Hold registers and overrun flags; a load into a full, ungranted register overwrites it
   always_comb begin
      flush      = start_acc || (run && stop_i) || (full_last && !pp_q);
      load       = adc_dvalid_i & chen_q & {NCH{run}};
      hold_vld_d = (hold_vld_q & ~arb_gnt) | load;
      ovf_d      = ovf_q | (load & hold_vld_q & ~arb_gnt);
      hold_dat_d = hold_dat_q;
      for (int c = 0; c < NCH; c++) begin
         if (load[c]) begin
            hold_dat_d[c] = adc_dat_i[c*DW +: DW];
         end
      end
      if (flush) begin
         hold_vld_d = '0;
      end
      if (start_acc) begin
         ovf_d = '0;
      end
   end

   // Write port, address counter and bank rotation
   always_comb begin
      waddr_d = waddr_q;
      bank_d  = bank_q;
      irq_d   = 1'b0;
      wenb_d  = '1;
      maddr_d = maddr_q;
      mdata_d = mdata_q;
      if (start_acc) begin
         waddr_d = '0;
         bank_d  = '0;
      end else if (wr_en) begin
         wenb_d  = ~(NBANK'(1) << bank_q);
         maddr_d = waddr_q;
         mdata_d = wr_word;
         if (waddr_q == last_q) begin
            waddr_d = '0;
            irq_d   = 1'b1;
            if (bank_q == BW'(NBANK - 1)) begin
               bank_d = pp_q ? '0 : bank_q;
            end else begin
               bank_d = bank_q + BW'(1);
            end
         end else begin
            waddr_d = waddr_q + AW'(1);
         end
      end
   end

   // Control and output registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= CAP_IDLE;
         pp_q       <= 1'b0;
         last_q     <= '0;
         chen_q     <= '0;
         hold_vld_q <= '0;
         ovf_q      <= '0;
         waddr_q    <= '0;
         bank_q     <= '0;
         wenb_q     <= '1;
         maddr_q    <= '0;
         mdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         if (start_acc) begin
            pp_q   <= pingpong_i;
            last_q <= last_addr_i;
            chen_q <= ch_en_i;
         end
         hold_vld_q <= hold_vld_d;
         ovf_q      <= ovf_d;
         waddr_q    <= waddr_d;
         bank_q     <= bank_d;
         wenb_q     <= wenb_d;
         maddr_q    <= maddr_d;
         mdata_q    <= mdata_d;
         irq_q      <= irq_d;
      end
   end

   // Sample payload; validity is tracked separately so no reset is needed here
   always_ff @(posedge wb_clk_i) begin
      hold_dat_q <= hold_dat_d;
   end

   assign mem_wenb_o  = wenb_q;
   assign mem_waddr_o = maddr_q;
   assign mem_data_o  = mdata_q;
   assign mem_wmask_o = '1;
   assign busy_o      = run;
   assign bank_o      = bank_q;
   assign irq_o       = irq_q;
   assign ovf_o       = ovf_q;

endmodule
